crossbar_pipe: RTL
==================

CROSSBAR_PIPE -- requirements
Module: crossbar_pipe

Interface
REQ-001 SHALL have parameter NPORTS, default 5: number of input ports and number of output ports.
REQ-002 SHALL have parameter WIDTH, default 8: flit width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, NPORTS*WIDTH bits: input port i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port in_valid, input, NPORTS bits: input i presents a flit.
REQ-007 SHALL have port in_ready, output, NPORTS bits: input i flit accepted this cycle when in_valid[i] and in_ready[i] are both high.
REQ-008 SHALL have port sel, input, NPORTS*NPORTS bits: field j, bits [j*NPORTS +: NPORTS], is the one-hot input select for output j.
REQ-009 SHALL have port out_data, output, NPORTS*WIDTH bits: registered output flits.
REQ-010 SHALL have port out_valid, output, NPORTS bits: output j holds a flit.
REQ-011 SHALL have port out_ready, input, NPORTS bits: downstream of output j accepts the flit this cycle.
REQ-012 SHALL have port sel_err, output, NPORTS bits: sticky flag set when output j saw an illegal select.

Function
REQ-013 SHALL treat output j as able to accept when !out_valid[j] or out_ready[j].
REQ-014 SHALL treat field j as legal when exactly one bit is set, idle when all bits are zero, and illegal otherwise.
REQ-015 SHALL assert in_ready[i] combinationally when at least one output has a legal select of i and every output with a legal select of i can accept.
REQ-016 SHALL hold in_ready[i] low when no output selects i.
REQ-017 SHALL, on a transfer at input i, load in_data[i] into every output with a legal select of i and set out_valid for each of them on the same edge; this implements multicast with one cycle of latency.
REQ-018 SHALL never load an output from an input that did not transfer, so a partial multicast is impossible.
REQ-019 SHALL clear out_valid[j] on an edge where out_valid[j] and out_ready[j] are high and no new load occurs; on simultaneous drain and load, out_valid stays high and the new data replaces the old.
REQ-020 SHALL hold out_data[j] and out_valid[j] stable while out_valid[j] is high and out_ready[j] is low.
REQ-021 SHALL make no transfer and no load for an output with an idle or illegal select.
REQ-022 SHALL set sel_err[j] on any edge where field j is illegal, and SHALL hold it until reset.
REQ-023 SHALL require in_valid and in_data to stay stable until accepted; the block does not check this.
REQ-024 SHALL have no combinational path from in_data to out_data.

Reset
REQ-025 SHALL, while rst_n is low, force out_valid=0, out_data=0, and sel_err=0 asynchronously.
REQ-026 SHALL, while rst_n is low, force in_ready=0.
REQ-027 SHALL discard any flit held at an output when reset is asserted mid-operation.
REQ-028 SHALL start accepting on the first rising edge after rst_n deasserts.

Verification
REQ-029 Unicast test: sel[0]=00100, in_valid[2]=1, in_data[2]=0xA5, out_ready=all 1 -> in_ready[2]=1; next edge: out_data[0]=0xA5, out_valid[0]=1.
REQ-030 Multicast test: sel[1]=sel[3]=00001, in_data[0]=0x3C, out_valid[3]=1 stalled with out_ready[3]=0 -> in_ready[0]=0 and no load; once out_ready[3]=1 -> both outputs show 0x3C on the next edge.
REQ-031 Back-pressure test: output 4 holds 0x11, out_ready[4]=0 for 5 cycles while a new flit waits -> out_data[4] stays 0x11; on release, 0x11 drains and the new flit loads on the same edge, with out_valid kept at 1.
REQ-032 Illegal-select test: sel[2]=00011 for 1 cycle -> no load on output 2; sel_err[2]=1 and stays set after sel returns to legal; the other outputs are unaffected.
REQ-033 Reset test: rst_n pulsed low mid-stream with all outputs valid -> out_valid=0, out_data=0, sel_err=0, and in_ready=0 immediately, without waiting for a clock edge.
REQ-034 Full-load test: a random legal permutation on all NPORTS ports with random out_ready over 10k cycles -> the scoreboard shows every accepted flit delivered exactly once per selecting output, in order, with none lost or duplicated.

Source files
------------

// File: rtl/crossbar_pipe.sv
`default_nettype none
// ============================================================================
// crossbar_pipe : NPORTS x NPORTS registered crossbar with one-hot selects,
//                 all-or-nothing multicast and sticky illegal-select flags.
// Revision      : 1.0
// ============================================================================
module crossbar_pipe #(
  parameter int NPORTS = 5,
  parameter int WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NPORTS*WIDTH-1:0]   in_data,
  input  logic [NPORTS-1:0]         in_valid,
  output logic [NPORTS-1:0]         in_ready,
  input  logic [NPORTS*NPORTS-1:0]  sel,
  output logic [NPORTS*WIDTH-1:0]   out_data,
  output logic [NPORTS-1:0]         out_valid,
  input  logic [NPORTS-1:0]         out_ready,
  output logic [NPORTS-1:0]         sel_err
);

  logic [NPORTS-1:0]        legal;
  logic [NPORTS-1:0]        illegal;
  logic [NPORTS-1:0]        can_acc;
  logic [NPORTS-1:0]        any_sel;
  logic [NPORTS-1:0]        all_ok;
  logic [NPORTS-1:0]        xfer;
  logic [NPORTS-1:0]        load;
  logic [NPORTS*WIDTH-1:0]  mux_data;

  logic [NPORTS-1:0]        out_valid_q, out_valid_d;
  logic [NPORTS-1:0]        sel_err_q,   sel_err_d;
  logic [NPORTS*WIDTH-1:0]  out_data_q,  out_data_d;

  generate
    for (genvar j = 0; j < NPORTS; j++) begin : g_field
      assign legal[j]   = $onehot(sel[j*NPORTS +: NPORTS]);
      assign illegal[j] = !$onehot0(sel[j*NPORTS +: NPORTS]);
      assign can_acc[j] = !out_valid_q[j] || out_ready[j];
    end
  endgenerate

  // An input is ready only if every output legally selecting it can take the
  // flit, so a multicast is either delivered everywhere or nowhere.
  always_comb begin
    any_sel = '0;
    all_ok  = '1;
    for (int i = 0; i < NPORTS; i++) begin
      for (int j = 0; j < NPORTS; j++) begin
        if (legal[j] && sel[j*NPORTS + i]) begin
          any_sel[i] = 1'b1;
          if (!can_acc[j]) all_ok[i] = 1'b0;
        end
      end
    end
  end

  assign in_ready = (rst_n ? (any_sel & all_ok) : '0);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    load     = '0;
    mux_data = '0;
    for (int j = 0; j < NPORTS; j++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (sel[j*NPORTS + i]) begin
          mux_data[j*WIDTH +: WIDTH] = mux_data[j*WIDTH +: WIDTH] | in_data[i*WIDTH +: WIDTH];
        end
      end
      load[j] = legal[j] && ((sel[j*NPORTS +: NPORTS] & xfer) != '0);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int j = 0; j < NPORTS; j++) begin
      if (load[j]) begin
        out_valid_d[j]              = 1'b1;
        out_data_d[j*WIDTH +: WIDTH] = mux_data[j*WIDTH +: WIDTH];
      end else if (out_ready[j]) begin
        out_valid_d[j] = 1'b0;
      end
    end
    sel_err_d = sel_err_q | illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      sel_err_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel_err   = sel_err_q;

endmodule
`default_nettype wire
